gpio_mmio: RTL and testbench
============================

Name: gpio_mmio

Overview:
- Memory-mapped GPIO responder serving CPU load/store requests on the board switches and LEDs.
- Drives the 16 LED pins from a CPU-writable register.
- Samples the 16 switch pins through a synchronizer and a per-bit debouncer, and exposes the debounced value plus sticky change flags as read registers.
- Sits between the cpu data-memory port and the top-level sw/led pins.

Parameters:
- ADDR_W, 32, request address width.
- BASE_ADDR, 32'h0000_1000, GPIO region base; the region is 32 bytes, aligned to 32.
- DEB_CYCLES, 16, clock cycles a switch must differ from its debounced value before it is accepted (min 2).
- CNT_W, 5, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data
- req_be  in  4  store byte enables
- resp_valid  out  1  response valid
- resp_ready  in  1  CPU accepts response
- resp_rdata  out  32  load data; 0 for stores and errors
- resp_err  out  1  unmapped or misaligned access
- sw  in  16  raw switch pins, asynchronous
- led  out  16  LED pins, registered

Behaviour:
- Reset (rst=0, async) forces:
  - led = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0
  - sync flops = 0, debounced sw_db = 0, change flags sw_chg = 0, all debounce counters = 0
  - FSM to IDLE
- Reset mid-transaction discards any pending response; no partial register write is retained.
- FSM states:
  - IDLE: req_ready = 1. An accept is req_valid & req_ready. On accept, perform the access and register its result, then go to RESP.
  - RESP: req_ready = 0, resp_valid = 1. Hold resp_rdata and resp_err stable until resp_ready = 1, then return to IDLE.
- Latency: resp_valid rises on the cycle after accept. Maximum throughput is one request every 2 cycles.
- Decode:
  - Hit when req_addr[ADDR_W-1:5] == BASE_ADDR[ADDR_W-1:5].
  - Offset is req_addr[4:0].
  - req_addr[1:0] != 0, a miss, or an undefined offset: resp_err = 1, resp_rdata = 0, no side effects.
- Register map:
  - 0x00 LED, RW. Bits [15:0] = led. Store: req_be[0] writes [7:0], req_be[1] writes [15:8]; be[3:2] ignored. Load returns {16'h0, led}.
  - 0x04 SW, RO. Load returns {16'h0, sw_db}. A store is ignored and is not an error.
  - 0x08 SW_CHG, W1C. Load returns {16'h0, sw_chg}. Store clears bits where wdata[i] = 1 and the corresponding byte enable is set.
  - 0x0C ID, RO. Returns 32'h6770_0001.
- led updates on the accept edge, so it is visible the cycle after accept.
- Switch path: 2-flop synchronizer produces sw_s. Each bit i has its own counter:
  - sw_s[i] == sw_db[i]: counter clears.
  - Otherwise counter increments. When it reaches DEB_CYCLES-1, sw_db[i] toggles, the counter clears and sw_chg[i] is set.
- Any bounce back to the debounced level before the count completes clears the counter; no change is recorded.
- Acceptance latency from a pin edge to sw_db is DEB_CYCLES + 2 cycles.
- Simultaneous W1C clear and new set of the same sw_chg bit: set wins.
- A load of SW/SW_CHG returns the values as they stand on the accept cycle.

Optional Feature:
- Macro GPIO_IRQ_EN.
- Defined:
  - Adds output irq (1 bit) and register 0x10 IRQ_MASK (RW, [15:0], same byte-enable rules as LED; reset value 0).
  - irq is registered: irq = |(sw_chg & irq_mask), one cycle after either operand changes; reset value 0.
- Undefined:
  - No irq port.
  - 0x10 is unmapped and returns resp_err = 1.

Test Plan:
- Reset, then load 0x1000 and 0x100C with resp_ready = 1:
  - rdata = 0 and then 32'h6770_0001, err = 0, resp_valid one cycle after each accept.
- Store 0x1000 wdata = 32'hFFFF_A5C3 with be = 4'b0001, then be = 4'b0010 with wdata = 32'h0000_7E00:
  - led = 16'h00C3, then 16'h7EC3; reading 0x1000 returns 32'h0000_7EC3.
- Set sw = 16'h0001 steady:
  - sw_db[0] rises exactly 18 cycles later with DEB_CYCLES = 16; SW_CHG reads 16'h0001.
  - Storing 0x1008 wdata = 1 clears it to 0.
- Toggle sw[3] for 10 cycles, then restore:
  - sw_db and sw_chg remain 0.
- Load 0x1002 (misaligned) and 0x2000 (miss):
  - resp_err = 1, rdata = 0, led unchanged.
  - Hold resp_ready = 0 for 5 cycles: resp_valid stays 1, outputs stable, req_ready = 0. Assert rst = 0 mid-hold: resp_valid drops immediately, led = 0.

Source files
------------

// File: rtl/gpio_mmio.sv
// gpio_mmio: memory-mapped GPIO responder for the board LEDs and switches.
// Latency: response one cycle after request accept; one request per 2 cycles max.
// Backpressure: req_ready low while a response is held; response held until resp_ready.
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_be : CPU request channel
//   resp_valid/resp_ready/resp_rdata/resp_err            : CPU response channel
//   sw  : raw asynchronous switch pins (synchronized + debounced internally)
//   led : registered LED pins
//   irq : only when GPIO_IRQ_EN is defined; OR of unmasked change flags
//
// Register map (offset from BASE_ADDR):
//   0x00 LED (RW), 0x04 SW (RO), 0x08 SW_CHG (W1C), 0x0C ID (RO),
//   0x10 IRQ_MASK (RW, only with GPIO_IRQ_EN)
module gpio_mmio #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0000_1000,
  parameter int                DEB_CYCLES = 16,
  parameter int                CNT_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  input  logic [15:0]       sw,
  output logic [15:0]       led
`ifdef GPIO_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RESP = 1'b1;

  localparam logic [31:0]      ID_VAL  = 32'h6770_0001;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [0:0]       state;
  logic [15:0]      sw_m, sw_s;
  logic [15:0]      sw_db, sw_chg;
  logic [CNT_W-1:0] cnt [16];
  logic [15:0]      deb_set;

  logic             accept, hit, acc_ok;
  logic [4:0]       off;
  logic [31:0]      rd_val;
  logic             dec_err;
  logic [15:0]      wmask;
  logic [15:0]      chg_clr;

`ifdef GPIO_IRQ_EN
  logic [15:0]      irq_mask;
`endif

  // Upper store bytes and byte enables have no register behind them.
  logic unused_bits;
  assign unused_bits = ^{req_wdata[31:16], req_be[3:2]};

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign accept     = req_valid & req_ready;

  assign hit    = (req_addr[ADDR_W-1:5] == BASE_ADDR[ADDR_W-1:5]);
  assign off    = req_addr[4:0];
  assign acc_ok = hit & (req_addr[1:0] == 2'b00) & ~dec_err;

  // Byte-lane write mask shared by LED, SW_CHG and IRQ_MASK.
  assign wmask = {{8{req_be[1]}}, {8{req_be[0]}}};

  always_comb begin
    rd_val  = 32'h0;
    dec_err = 1'b0;
    case (off)
      5'h00: rd_val = {16'h0, led};
      5'h04: rd_val = {16'h0, sw_db};
      5'h08: rd_val = {16'h0, sw_chg};
      5'h0C: rd_val = ID_VAL;
`ifdef GPIO_IRQ_EN
      5'h10: rd_val = {16'h0, irq_mask};
`endif
      default: dec_err = 1'b1;
    endcase
  end

  assign chg_clr = (accept & req_we & acc_ok & (off == 5'h08))
                 ? (req_wdata[15:0] & wmask) : 16'h0;

  // Request FSM and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state      <= S_RESP;
            resp_err   <= ~acc_ok;
            resp_rdata <= (req_we | ~acc_ok) ? 32'h0 : rd_val;
          end
        end
        default: begin
          if (resp_ready) state <= S_IDLE;
        end
      endcase
    end
  end

  // LED register, written on the accept edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led <= 16'h0;
    end else if (accept & req_we & acc_ok & (off == 5'h00)) begin
      led <= (led & ~wmask) | (req_wdata[15:0] & wmask);
    end
  end

`ifdef GPIO_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_mask <= 16'h0;
      irq      <= 1'b0;
    end else begin
      if (accept & req_we & acc_ok & (off == 5'h10))
        irq_mask <= (irq_mask & ~wmask) | (req_wdata[15:0] & wmask);
      irq <= |(sw_chg & irq_mask);
    end
  end
`endif

  // Two-flop synchronizer for the asynchronous switch pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_m <= 16'h0;
      sw_s <= 16'h0;
    end else begin
      sw_m <= sw;
      sw_s <= sw_m;
    end
  end

  // A bit is accepted on the cycle its counter is already at CNT_MAX and the
  // mismatch persists, giving DEB_CYCLES mismatching cycles in total.
  always_comb begin
    deb_set = 16'h0;
    for (int i = 0; i < 16; i++)
      deb_set[i] = (sw_s[i] != sw_db[i]) && (cnt[i] == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_db  <= 16'h0;
      sw_chg <= 16'h0;
      for (int i = 0; i < 16; i++) cnt[i] <= '0;
    end else begin
      sw_db  <= sw_db ^ deb_set;
      // A new change event overrides a concurrent W1C clear.
      sw_chg <= (sw_chg & ~chg_clr) | deb_set;
      for (int i = 0; i < 16; i++) begin
        if ((sw_s[i] == sw_db[i]) || deb_set[i]) cnt[i] <= '0;
        else                                     cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gpio_mmio.sv
// tb_gpio_mmio: directed self-checking bench for gpio_mmio.
// Latency: n/a (bench).
// Backpressure: exercises resp_ready hold and reset during a held response.
module tb_gpio_mmio;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [15:0] sw;
  logic [15:0] led;
`ifdef GPIO_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  gpio_mmio dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .sw         (sw),
    .led        (led)
`ifdef GPIO_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request starting just after a clock edge. With resp_ready high
  // the response is consumed on the following edge; otherwise it is left held.
  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rdata, output logic err);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    chk("resp_valid_lat", {31'h0, resp_valid}, 32'h1);
    rdata = resp_rdata;
    err   = resp_err;
    if (resp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;

    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_be     = 4'h0;
    resp_ready = 1'b1;
    sw         = 16'h0;

    #22;
    chk("rst_led",        {16'h0, led},         32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid},  32'h0);
    chk("rst_rdata",      resp_rdata,           32'h0);
    chk("rst_err",        {31'h0, resp_err},    32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_req_ready",  {31'h0, req_ready},   32'h1);

    // Basic loads.
    bus(1'b0, 32'h1000, 32'h0, 4'h0, rd, er);
    chk("ld_led_rdata", rd, 32'h0);
    chk("ld_led_err",   {31'h0, er}, 32'h0);
    bus(1'b0, 32'h100C, 32'h0, 4'h0, rd, er);
    chk("ld_id_rdata", rd, 32'h6770_0001);
    chk("ld_id_err",   {31'h0, er}, 32'h0);

    // LED byte-lane stores.
    bus(1'b1, 32'h1000, 32'hFFFF_A5C3, 4'b0001, rd, er);
    chk("st_led_b0",     {16'h0, led}, 32'h0000_00C3);
    chk("st_led_rdata0", rd, 32'h0);
    bus(1'b1, 32'h1000, 32'h0000_7E00, 4'b0010, rd, er);
    chk("st_led_b1", {16'h0, led}, 32'h0000_7EC3);
    bus(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'b1100, rd, er);
    chk("st_led_hi_be", {16'h0, led}, 32'h0000_7EC3);
    bus(1'b0, 32'h1000, 32'h0, 4'h0, rd, er);
    chk("ld_led_back", rd, 32'h0000_7EC3);

    // Store to read-only SW is silently ignored.
    bus(1'b1, 32'h1004, 32'hFFFF_FFFF, 4'hF, rd, er);
    chk("st_sw_err", {31'h0, er}, 32'h0);

`ifdef GPIO_IRQ_EN
    bus(1'b0, 32'h1010, 32'h0, 4'h0, rd, er);
    chk("ld_mask_err", {31'h0, er}, 32'h0);
`else
    bus(1'b0, 32'h1010, 32'h0, 4'h0, rd, er);
    chk("ld_0x10_err",   {31'h0, er}, 32'h1);
    chk("ld_0x10_rdata", rd, 32'h0);
`endif

    // Debounce timing: pin change lands on sw_db on the 18th edge.
    sw = 16'h0001;
    for (int i = 0; i < 17; i++) @(posedge clk);
    #1;
    chk("deb_edge17", {16'h0, dut.sw_db}, 32'h0);
    @(posedge clk);
    #1;
    chk("deb_edge18", {16'h0, dut.sw_db}, 32'h1);
    bus(1'b0, 32'h1004, 32'h0, 4'h0, rd, er);
    chk("ld_sw", rd, 32'h0000_0001);
    bus(1'b0, 32'h1008, 32'h0, 4'h0, rd, er);
    chk("ld_chg_set", rd, 32'h0000_0001);
    bus(1'b1, 32'h1008, 32'h0000_0001, 4'b0000, rd, er);
    bus(1'b0, 32'h1008, 32'h0, 4'h0, rd, er);
    chk("w1c_no_be", rd, 32'h0000_0001);
    bus(1'b1, 32'h1008, 32'h0000_0001, 4'b0001, rd, er);
    bus(1'b0, 32'h1008, 32'h0, 4'h0, rd, er);
    chk("w1c_clear", rd, 32'h0);

    // Bouncing sw[3] never settles long enough to be accepted.
    for (int i = 0; i < 10; i++) begin
      sw[3] = ~sw[3];
      @(posedge clk);
      #1;
    end
    sw[3] = 1'b0;
    for (int i = 0; i < 30; i++) @(posedge clk);
    #1;
    chk("bounce_db", {16'h0, dut.sw_db}, 32'h0000_0001);
    bus(1'b0, 32'h1008, 32'h0, 4'h0, rd, er);
    chk("bounce_chg", rd, 32'h0);

    // Error responses have no side effects.
    bus(1'b0, 32'h1002, 32'h0, 4'h0, rd, er);
    chk("mis_err",   {31'h0, er}, 32'h1);
    chk("mis_rdata", rd, 32'h0);
    bus(1'b1, 32'h1002, 32'h0000_FFFF, 4'hF, rd, er);
    chk("mis_st_err", {31'h0, er}, 32'h1);
    bus(1'b1, 32'h2000, 32'h0000_FFFF, 4'hF, rd, er);
    chk("miss_st_err", {31'h0, er}, 32'h1);
    chk("miss_led",    {16'h0, led}, 32'h0000_7EC3);
    bus(1'b0, 32'h2000, 32'h0, 4'h0, rd, er);
    chk("miss_err",   {31'h0, er}, 32'h1);
    chk("miss_rdata", rd, 32'h0);

    // Held response, then reset while it is pending.
    resp_ready = 1'b0;
    bus(1'b0, 32'h2000, 32'h0, 4'h0, rd, er);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'h0, resp_valid}, 32'h1);
      chk("hold_err",   {31'h0, resp_err},   32'h1);
      chk("hold_rdata", resp_rdata,          32'h0);
      chk("hold_ready", {31'h0, req_ready},  32'h0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, resp_valid}, 32'h0);
    chk("mid_rst_led",   {16'h0, led},        32'h0);
    chk("mid_rst_ready", {31'h0, req_ready},  32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
